seg_display_monitor: RTL and testbench

- Inverse of the team's hex-to-seven-segment display path: samples the multiplexed, active-low segment/anode bus going to the 4-digit display.
- Filters each digit for stability and encodes the stable glyph back to a 4-bit hex code.
- Presents the assembled 16-bit value over a valid/ready handshake.
- Used for on-board loopback checking of the display driver and for self-checking benches.

---
 rtl/seg_monitor_pkg.sv | 46 ++++
 rtl/seg_digit_filter.sv | 38 +++
 rtl/seg_display_monitor.sv | 93 +++++++++
 tb/tb_seg_display_monitor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg_monitor_pkg.sv
// seg_monitor_pkg: glyph table, encoder and FSM state type for the segment display monitor.
package seg_monitor_pkg;
  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0001100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {COLLECT, PRESENT} state_e;

  // Returns {err, blank, code[3:0]}; blank and err both encode code 0.
  function automatic logic [5:0] encode(input logic [6:0] seg);
    case (seg)
      GLYPH_0:   encode = 6'h00;
      GLYPH_1:   encode = 6'h01;
      GLYPH_2:   encode = 6'h02;
      GLYPH_3:   encode = 6'h03;
      GLYPH_4:   encode = 6'h04;
      GLYPH_5:   encode = 6'h05;
      GLYPH_6:   encode = 6'h06;
      GLYPH_7:   encode = 6'h07;
      GLYPH_8:   encode = 6'h08;
      GLYPH_9:   encode = 6'h09;
      GLYPH_A:   encode = 6'h0a;
      GLYPH_B:   encode = 6'h0b;
      GLYPH_C:   encode = 6'h0c;
      GLYPH_D:   encode = 6'h0d;
      GLYPH_E:   encode = 6'h0e;
      GLYPH_F:   encode = 6'h0f;
      SEG_BLANK: encode = 6'h10;
      default:   encode = 6'h20;
    endcase
  endfunction
endpackage

// File: rtl/seg_digit_filter.sv
// seg_digit_filter: per-digit stability filter; pulses commit_o on every sample that leaves the
// count at STABLE_CNT, so a steadily scanned digit re-commits for each new frame.
module seg_digit_filter
  import seg_monitor_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_i,
  input  logic [6:0] seg_i,
  output logic       commit_o,
  output logic [5:0] enc_o
);
  localparam logic [7:0] LIM = 8'(STABLE_CNT);

  logic [6:0] pat_q, pat_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    pat_d = sample_i ? seg_i : pat_q;
    cnt_d = !sample_i      ? cnt_q :
            seg_i != pat_q ? 8'd1  :
            cnt_q == LIM   ? cnt_q : cnt_q + 8'd1;
    commit_o = sample_i && cnt_d == LIM;
    enc_o = encode(seg_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/seg_display_monitor.sv
// seg_display_monitor: decodes the multiplexed active-low segment/anode bus back into hex digits
// and presents each fully committed frame over a valid/ready handshake.
module seg_display_monitor
  import seg_monitor_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   an,
  output logic [4*NDIG-1:0] out_value,
  output logic [NDIG-1:0]   out_blank,
  output logic [NDIG-1:0]   out_err,
  output logic              out_valid,
  input  logic              out_ready
);
  logic [NDIG-1:0]   samp, commit, cmt_q, cmt_d;
  logic [5:0]        enc [NDIG];
  logic [4*NDIG-1:0] sh_val_q, sh_val_d, val_q, val_d;
  logic [NDIG-1:0]   sh_blank_q, sh_blank_d, sh_err_q, sh_err_d;
  logic [NDIG-1:0]   blank_q, blank_d, err_q, err_d;
  logic              hs, load;
  state_e            state_q, state_d;

  // Only a bus with exactly one anode low is a usable sample.
  always_comb samp = $onehot(~an) ? ~an : '0;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    seg_digit_filter #(.STABLE_CNT(STABLE_CNT)) u_filt (
      .clk      (clk),
      .rst_n    (rst_n),
      .sample_i (samp[g]),
      .seg_i    (seg),
      .commit_o (commit[g]),
      .enc_o    (enc[g])
    );
  end

  always_comb begin
    sh_val_d   = sh_val_q;
    sh_blank_d = sh_blank_q;
    sh_err_d   = sh_err_q;
    for (int i = 0; i < NDIG; i++) begin
      if (commit[i]) begin
        sh_val_d[4*i+:4] = enc[i][3:0];
        sh_blank_d[i]    = enc[i][4];
        sh_err_d[i]      = enc[i][5];
      end
    end
  end

  always_comb begin
    hs      = state_q == PRESENT && out_ready;
    load    = state_q == COLLECT && &cmt_q;
    cmt_d   = (hs ? '0 : cmt_q) | commit;
    val_d   = load ? sh_val_q : val_q;
    blank_d = load ? sh_blank_q : blank_q;
    err_d   = load ? sh_err_q : err_q;
  end

  always_comb state_d = load ? PRESENT : hs ? COLLECT : state_q;

  always_comb begin
    out_valid = state_q == PRESENT;
    out_value = val_q;
    out_blank = blank_q;
    out_err   = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      cmt_q      <= '0;
      sh_val_q   <= '0;
      sh_blank_q <= '0;
      sh_err_q   <= '0;
      val_q      <= '0;
      blank_q    <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmt_q      <= cmt_d;
      sh_val_q   <= sh_val_d;
      sh_blank_q <= sh_blank_d;
      sh_err_q   <= sh_err_d;
      val_q      <= val_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_seg_display_monitor.sv
// tb_seg_display_monitor: directed vectors with hand-computed expectations for seg_display_monitor.
module tb_seg_display_monitor;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] BAD = 7'b1010101;

  logic        clk, rst_n, out_valid, out_ready;
  logic [6:0]  seg;
  logic [3:0]  an, out_blank, out_err;
  logic [15:0] out_value;
  int vec = 0;
  int miss = 0;

  seg_display_monitor #(.NDIG(4), .STABLE_CNT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .out_value (out_value),
    .out_blank (out_blank),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    an = 4'b1111;
    repeat (n) tick();
  endtask

  task automatic samp(input int d, input logic [6:0] s, input int n);
    logic [3:0] m;
    m = 4'b0001 << d;
    an = ~m;
    seg = s;
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    an = 4'b1111;
    seg = BLK;
    out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_value", out_value, 16'h0000);
    chk("rst_blank", {12'd0, out_blank}, 16'd0);
    chk("rst_err", {12'd0, out_err}, 16'd0);
    rst_n = 1'b1;
    tick();
    // frame 1: glyphs 1,2,3,4 with ready high
    out_ready = 1'b1;
    samp(0, G1, 4);
    samp(1, G2, 4);
    samp(2, G3, 4);
    samp(3, G4, 4);
    chk("f1_valid_last_commit", {15'd0, out_valid}, 16'd0);
    idle(1);
    chk("f1_valid", {15'd0, out_valid}, 16'd1);
    chk("f1_value", out_value, 16'h4321);
    chk("f1_blank", {12'd0, out_blank}, 16'd0);
    chk("f1_err", {12'd0, out_err}, 16'd0);
    idle(1);
    chk("f1_valid_one_cycle", {15'd0, out_valid}, 16'd0);
    // frame 2 held with ready low while digit 0 changes to 7
    out_ready = 1'b0;
    samp(0, G1, 1);
    samp(1, G2, 1);
    samp(2, G3, 1);
    samp(3, G4, 1);
    idle(1);
    chk("f2_valid", {15'd0, out_valid}, 16'd1);
    chk("f2_value", out_value, 16'h4321);
    samp(0, G7, 4);
    idle(6);
    chk("f2_hold_valid", {15'd0, out_valid}, 16'd1);
    chk("f2_hold_value", out_value, 16'h4321);
    out_ready = 1'b1;
    idle(1);
    chk("f2_accept", {15'd0, out_valid}, 16'd0);
    samp(0, G7, 1);
    samp(1, G2, 1);
    samp(2, G3, 1);
    idle(1);
    chk("f3_three_digits", {15'd0, out_valid}, 16'd0);
    samp(3, G4, 1);
    chk("f3_pre", {15'd0, out_valid}, 16'd0);
    idle(1);
    chk("f3_valid", {15'd0, out_valid}, 16'd1);
    chk("f3_value", out_value, 16'h4327);
    idle(1);
    chk("f3_accept", {15'd0, out_valid}, 16'd0);
    // digit 2 toggles every 3 samples, never stable
    samp(0, G7, 1);
    samp(1, G2, 1);
    samp(3, G4, 1);
    samp(2, G5, 3);
    samp(2, G3, 3);
    samp(2, G5, 3);
    samp(2, G3, 3);
    idle(1);
    chk("tog_no_commit", {15'd0, out_valid}, 16'd0);
    samp(2, G5, 4);
    chk("tog_commit_pre", {15'd0, out_valid}, 16'd0);
    idle(1);
    chk("tog_valid", {15'd0, out_valid}, 16'd1);
    chk("tog_value", out_value, 16'h4527);
    idle(1);
    chk("tog_accept", {15'd0, out_valid}, 16'd0);
    // non-qualifying anode patterns between samples of digit 1
    samp(0, G7, 1);
    samp(2, G5, 1);
    samp(3, G4, 1);
    samp(1, G1, 1);
    an = 4'b1111; seg = G2; tick();
    samp(1, G1, 1);
    an = 4'b0011; seg = G3; tick();
    samp(1, G1, 1);
    idle(1);
    chk("noq_three", {15'd0, out_valid}, 16'd0);
    samp(1, G1, 1);
    chk("noq_fourth_pre", {15'd0, out_valid}, 16'd0);
    idle(1);
    chk("noq_valid", {15'd0, out_valid}, 16'd1);
    chk("noq_value", out_value, 16'h4517);
    idle(1);
    chk("noq_accept", {15'd0, out_valid}, 16'd0);
    // blank on digit 1, non-glyph on digit 3, held in PRESENT
    out_ready = 1'b0;
    samp(0, G7, 1);
    samp(2, G5, 1);
    samp(1, BLK, 4);
    samp(3, BAD, 4);
    idle(1);
    chk("be_valid", {15'd0, out_valid}, 16'd1);
    chk("be_value", out_value, 16'h0507);
    chk("be_blank", {12'd0, out_blank}, 16'h0002);
    chk("be_err", {12'd0, out_err}, 16'h0008);
    // async reset mid-PRESENT
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {15'd0, out_valid}, 16'd0);
    chk("ar_value", out_value, 16'h0000);
    chk("ar_blank", {12'd0, out_blank}, 16'd0);
    chk("ar_err", {12'd0, out_err}, 16'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    samp(0, G1, 1);
    samp(1, G2, 1);
    samp(2, G3, 1);
    samp(3, G4, 1);
    idle(1);
    chk("ar_partial", {15'd0, out_valid}, 16'd0);
    samp(0, G1, 3);
    samp(1, G2, 3);
    samp(2, G3, 3);
    samp(3, G4, 3);
    idle(1);
    chk("ar_new_valid", {15'd0, out_valid}, 16'd1);
    chk("ar_new_value", out_value, 16'h4321);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
